// File: rtl/load_store_unit.sv
// Data-memory stage: runs one or two word-wide bus beats per load/store and returns
// lane-aligned, extended load data. Misaligned accesses are split or rejected per MISALIGN_SPLIT.
module load_store_unit #(
  parameter int unsigned MISALIGN_SPLIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Start,
  input  logic [3:0]  CtrlLSU,
  input  logic [31:0] Address,
  input  logic [31:0] StoreData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] LoadData,
  output logic        Misaligned,
  output logic        MemReq,
  output logic        MemWe,
  output logic [31:0] MemAddr,
  output logic [3:0]  MemBE,
  output logic [31:0] MemWData,
  input  logic        MemAck,
  input  logic [31:0] MemRData
);

  typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q;
  logic [29:0] word_q;
  logic [1:0]  off_q;
  logic [31:0] sdata_q, rdata0_q, load_q;
  logic        split_q, done_q, misal_q;

  function automatic logic [2:0] size_of(input logic [1:0] w);
    unique case (w)
      2'b01:   return 3'd4;
      2'b10:   return 3'd2;
      2'b11:   return 3'd1;
      default: return 3'd0;
    endcase
  endfunction

  logic [2:0]  start_size;
  logic        start_split, accept, reject, complete;
  logic [3:0]  size_mask;
  logic [7:0]  lane_mask;
  logic [63:0] wdata64, raw64;
  logic [31:0] rdata_hi, rdata_lo, raw, ext;
  logic        sext;

  assign start_size  = size_of(CtrlLSU[1:0]);
  assign start_split = ({2'b00, Address[1:0]} + {1'b0, start_size}) > 4'd4;
  assign accept      = Start && (state_q == StIdle) && (CtrlLSU[1:0] != 2'b00);
  assign reject      = accept && start_split && (MISALIGN_SPLIT == 0);

  // Lanes and data are computed across an 8-byte window; upper half belongs to beat 1.
  always_comb begin
    unique case (ctrl_q[1:0])
      2'b10:   size_mask = 4'b0011;
      2'b11:   size_mask = 4'b0001;
      default: size_mask = 4'b1111;
    endcase
  end
  assign lane_mask = {4'b0000, size_mask} << off_q;
  assign wdata64   = {32'h0, sdata_q} << {off_q, 3'b000};

  assign rdata_hi = (state_q == StBeat1) ? MemRData : 32'h0;
  assign rdata_lo = (state_q == StBeat1) ? rdata0_q : MemRData;
  assign raw64    = {rdata_hi, rdata_lo} >> {off_q, 3'b000};
  assign raw      = raw64[31:0];
  assign sext     = !ctrl_q[3];

  always_comb begin
    unique case (ctrl_q[1:0])
      2'b10:   ext = {{16{sext & raw[15]}}, raw[15:0]};
      2'b11:   ext = {{24{sext & raw[7]}}, raw[7:0]};
      default: ext = raw;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    unique case (state_q)
      StIdle:  if (accept && !reject) state_d = StBeat0;
      StBeat0: if (MemAck) begin
        state_d  = split_q ? StBeat1 : StIdle;
        complete = !split_q;
      end
      StBeat1: if (MemAck) begin
        state_d  = StIdle;
        complete = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    MemReq   = 1'b0;
    MemWe    = 1'b0;
    MemAddr  = 32'h0;
    MemBE    = 4'h0;
    MemWData = 32'h0;
    unique case (state_q)
      StBeat0: begin
        MemReq   = 1'b1;
        MemWe    = ctrl_q[2];
        MemAddr  = {word_q, 2'b00};
        MemBE    = lane_mask[3:0];
        MemWData = wdata64[31:0];
      end
      StBeat1: begin
        MemReq   = 1'b1;
        MemWe    = ctrl_q[2];
        MemAddr  = {word_q + 30'd1, 2'b00};
        MemBE    = lane_mask[7:4];
        MemWData = wdata64[63:32];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ctrl_q   <= 4'h0;
      word_q   <= 30'h0;
      off_q    <= 2'b00;
      sdata_q  <= 32'h0;
      rdata0_q <= 32'h0;
      split_q  <= 1'b0;
      done_q   <= 1'b0;
      misal_q  <= 1'b0;
      load_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      done_q  <= complete || reject;
      misal_q <= reject;
      if (accept) begin
        ctrl_q  <= CtrlLSU;
        word_q  <= Address[31:2];
        off_q   <= Address[1:0];
        sdata_q <= StoreData;
        split_q <= start_split;
      end
      if (state_q == StBeat0 && MemAck) rdata0_q <= MemRData;
      if (complete && !ctrl_q[2]) load_q <= ext;
    end
  end

  assign Busy       = (state_q != StIdle);
  assign Done       = done_q;
  assign Misaligned = misal_q;
  assign LoadData   = load_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: a byte-level memory-access model predicts every bus beat and
// the load result; a negedge process compares the DUT against it each cycle.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst, start, busy, done, misal, mem_req, mem_we, mem_ack;
  logic [3:0]  ctrl, mem_be;
  logic [31:0] addr, sdata, load_data, mem_addr, mem_wdata, mem_rdata;

  logic        start1, busy1, done1, misal1, mem_req1, mem_we1;
  logic [3:0]  ctrl1, mem_be1;
  logic [31:0] addr1, load_data1, mem_addr1, mem_wdata1;

  always #5 clk = ~clk;

  load_store_unit #(.MISALIGN_SPLIT(1)) u_dut (
    .clk(clk), .rst(rst), .Start(start), .CtrlLSU(ctrl), .Address(addr), .StoreData(sdata),
    .Busy(busy), .Done(done), .LoadData(load_data), .Misaligned(misal), .MemReq(mem_req),
    .MemWe(mem_we), .MemAddr(mem_addr), .MemBE(mem_be), .MemWData(mem_wdata),
    .MemAck(mem_ack), .MemRData(mem_rdata)
  );

  load_store_unit #(.MISALIGN_SPLIT(0)) u_dut_nosplit (
    .clk(clk), .rst(rst), .Start(start1), .CtrlLSU(ctrl1), .Address(addr1),
    .StoreData(32'h0), .Busy(busy1), .Done(done1), .LoadData(load_data1),
    .Misaligned(misal1), .MemReq(mem_req1), .MemWe(mem_we1), .MemAddr(mem_addr1),
    .MemBE(mem_be1), .MemWData(mem_wdata1), .MemAck(mem_req1), .MemRData(32'h0000ABCD)
  );

  int checks = 0;
  int failures = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: walk the accessed bytes one by one, placing each in its word and lane.
  logic [31:0] m_addr[2], m_wd[2], m_rd[2], m_load;
  logic [3:0]  m_be[2];
  int          m_nb;

  task automatic model(input logic [3:0] c, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] rd0, input logic [31:0] rd1);
    int size, b, lane;
    logic [31:0] ba, res;
    size = (c[1:0] == 2'b01) ? 4 : (c[1:0] == 2'b10) ? 2 : 1;
    m_rd[0] = rd0;
    m_rd[1] = rd1;
    m_nb = 1;
    for (int k = 0; k < 2; k++) begin
      m_be[k] = 4'h0;
      m_wd[k] = 32'h0;
      m_addr[k] = {a[31:2], 2'b00} + 32'(4 * k);
    end
    res = 32'h0;
    for (int i = 0; i < size; i++) begin
      ba = a + 32'(i);
      b = (ba[31:2] == a[31:2]) ? 0 : 1;
      lane = int'(ba[1:0]);
      if (b == 1) m_nb = 2;
      m_be[b][lane] = 1'b1;
      m_wd[b][8*lane +: 8] = sd[8*i +: 8];
      res[8*i +: 8] = m_rd[b][8*lane +: 8];
    end
    if (!c[3] && size < 4 && res[8*size-1])
      for (int i = size; i < 4; i++) res[8*i +: 8] = 8'hFF;
    m_load = res;
  endtask

  logic        chk_en = 1'b0;
  logic        e_req, e_we, e_busy, e_done;
  logic [31:0] e_addr, e_wd, e_load;
  logic [3:0]  e_be;

  task automatic exp_idle();
    e_req = 0; e_we = 0; e_busy = 0; e_done = 0; e_addr = 0; e_be = 0; e_wd = 0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("Busy", {31'h0, busy}, {31'h0, e_busy});
      cmp("Done", {31'h0, done}, {31'h0, e_done});
      cmp("Misaligned", {31'h0, misal}, 32'h0);
      cmp("MemReq", {31'h0, mem_req}, {31'h0, e_req});
      cmp("MemWe", {31'h0, mem_we}, {31'h0, e_we});
      cmp("MemAddr", mem_addr, e_addr);
      cmp("MemBE", {28'h0, mem_be}, {28'h0, e_be});
      if (e_we) cmp("MemWData", mem_wdata, e_wd);
      cmp("LoadData", load_data, e_load);
    end
  end

  task automatic txn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] rd0, input logic [31:0] rd1, input int wait0,
                     input bit poke);
    model(c, a, sd, rd0, rd1);
    @(posedge clk); #1;
    start = 1; ctrl = c; addr = a; sdata = sd; mem_ack = 0;
    exp_idle();
    @(posedge clk); #1;
    start = 0;
    for (int b = 0; b < m_nb; b++) begin
      for (int w = 0; w <= ((b == 0) ? wait0 : 0); w++) begin
        e_req = 1; e_busy = 1; e_we = c[2]; e_done = 0;
        e_addr = m_addr[b]; e_be = m_be[b]; e_wd = m_wd[b];
        mem_ack = (w == ((b == 0) ? wait0 : 0));
        mem_rdata = mem_ack ? m_rd[b] : 32'h5A5A5A5A;
        if (poke && b == 0 && w == 0) begin
          start = 1; ctrl = 4'b0011; addr = 32'h40;
        end
        @(posedge clk); #1;
        start = 0;
      end
    end
    mem_ack = 0;
    exp_idle();
    e_done = 1;
    if (!c[2]) e_load = m_load;
    @(posedge clk); #1;
    e_done = 0;
  endtask

  initial begin
    rst = 1; start = 0; ctrl = 0; addr = 0; sdata = 0; mem_ack = 0; mem_rdata = 0;
    start1 = 0; ctrl1 = 0; addr1 = 0;
    exp_idle();
    e_load = 0;
    @(posedge clk); #1;
    chk_en = 1;
    cmp("rst_load1", load_data1, 32'h0);
    @(posedge clk); #1;
    rst = 0;

    model(4'b0010, 32'h102, 32'h0, 32'h80011234, 32'h0);
    cmp("model_lh", m_load, 32'hFFFF8001);
    model(4'b0101, 32'h203, 32'h11223344, 32'h0, 32'h0);
    cmp("model_sw_a1", m_addr[1], 32'h204);
    cmp("model_sw_be0", {28'h0, m_be[0]}, 32'h8);
    cmp("model_sw_wd0", m_wd[0], 32'h44000000);
    cmp("model_sw_be1", {28'h0, m_be[1]}, 32'h7);
    cmp("model_sw_wd1", m_wd[1], 32'h00112233);

    txn(4'b0001, 32'h100, 32'h0, 32'hDEADBEEF, 32'h0, 0, 0);
    cmp("lw_100", load_data, 32'hDEADBEEF);
    txn(4'b0010, 32'h102, 32'h0, 32'h80011234, 32'h0, 0, 0);
    cmp("lh_102", load_data, 32'hFFFF8001);
    txn(4'b1010, 32'h102, 32'h0, 32'h80011234, 32'h0, 0, 0);
    cmp("lhu_102", load_data, 32'h00008001);
    txn(4'b1011, 32'h103, 32'h0, 32'h80011234, 32'h0, 0, 0);
    cmp("lbu_103", load_data, 32'h00000080);
    txn(4'b0101, 32'h203, 32'h11223344, 32'h0, 32'h0, 0, 0);
    cmp("sw_keeps_load", load_data, 32'h00000080);
    txn(4'b0001, 32'hFFFFFFFE, 32'h0, 32'hBBAA0000, 32'h0000DDCC, 0, 0);
    cmp("lw_wrap", load_data, 32'hDDCCBBAA);
    txn(4'b0001, 32'h300, 32'h0, 32'hCAFEF00D, 32'h0, 3, 1);
    cmp("lw_wait", load_data, 32'hCAFEF00D);
    txn(4'b0110, 32'h301, 32'h0000BEEF, 32'h0, 32'h0, 1, 0);
    txn(4'b0110, 32'h103, 32'h0000A55A, 32'h0, 32'h0, 0, 0);
    txn(4'b0011, 32'h12, 32'h0, 32'h00800000, 32'h0, 0, 0);
    cmp("lb_sign", load_data, 32'hFFFFFF80);
    txn(4'b0010, 32'h7F, 32'h0, 32'h12000000, 32'h00000034, 2, 0);

    // LSN width: no activity
    @(posedge clk); #1;
    start = 1; ctrl = 4'b0100; addr = 32'h500;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;

    // Reset while waiting on beat 0, then a late ack
    model(4'b0001, 32'h400, 32'h0, 32'h0, 32'h0);
    start = 1; ctrl = 4'b0001; addr = 32'h400;
    @(posedge clk); #1;
    start = 0;
    e_req = 1; e_busy = 1; e_addr = 32'h400; e_be = 4'hF;
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0; mem_ack = 1; mem_rdata = 32'h01020304;
    exp_idle();
    e_load = 0;
    @(posedge clk); #1;
    mem_ack = 0;
    @(posedge clk); #1;
    txn(4'b0001, 32'h600, 32'h0, 32'h0BADF00D, 32'h0, 0, 0);
    cmp("after_rst", load_data, 32'h0BADF00D);

    // Non-splitting instance: rejected word, LSN, then an aligned halfword
    start1 = 1; ctrl1 = 4'b0001; addr1 = 32'h101;
    @(posedge clk); #1;
    start1 = 0;
    cmp("rej_done", {31'h0, done1}, 32'h1);
    cmp("rej_misal", {31'h0, misal1}, 32'h1);
    cmp("rej_req", {31'h0, mem_req1}, 32'h0);
    cmp("rej_busy", {31'h0, busy1}, 32'h0);
    @(posedge clk); #1;
    cmp("rej_done_pulse", {31'h0, done1}, 32'h0);
    cmp("rej_load", load_data1, 32'h0);
    start1 = 1; ctrl1 = 4'b0000; addr1 = 32'h100;
    @(posedge clk); #1;
    start1 = 0;
    cmp("lsn_busy", {31'h0, busy1}, 32'h0);
    cmp("lsn_req", {31'h0, mem_req1}, 32'h0);
    cmp("lsn_done", {31'h0, done1}, 32'h0);
    start1 = 1; ctrl1 = 4'b0010; addr1 = 32'h100;
    @(posedge clk); #1;
    start1 = 0;
    cmp("ns_req", {31'h0, mem_req1}, 32'h1);
    cmp("ns_be", {28'h0, mem_be1}, 32'h3);
    @(posedge clk); #1;
    cmp("ns_done", {31'h0, done1}, 32'h1);
    cmp("ns_misal", {31'h0, misal1}, 32'h0);
    cmp("ns_load", load_data1, 32'hFFFFABCD);
    @(posedge clk); #1;
    chk_en = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
